// File: rtl/alu_result_select_seq_if.sv
// Result-select bus: operation-unit channels in, registered result and flags out.
// The master side drives the request and channel signals; the slave side is the selector.
interface alu_result_select_seq_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 8,
    parameter int SELW  = 3
) ();
    logic                   start;
    logic [SELW-1:0]        sel;
    logic [NCH*WIDTH-1:0]   ch_data;
    logic [NCH-1:0]         ch_done;
    logic [NCH-1:0]         ch_carry;
    logic [WIDTH-1:0]       result;
    logic                   valid;
    logic                   busy;
    logic                   flag_zero;
    logic                   flag_neg;
    logic                   flag_carry;
    logic                   err;

    modport master (
        output start, sel, ch_data, ch_done, ch_carry,
        input  result, valid, busy, flag_zero, flag_neg, flag_carry, err
    );

    modport slave (
        input  start, sel, ch_data, ch_done, ch_carry,
        output result, valid, busy, flag_zero, flag_neg, flag_carry, err
    );
endinterface

// File: rtl/alu_result_select_seq.sv
// Registered ALU result selector: picks one operation channel, waits for its
// done strobe (or a timeout), then registers result, flags and a valid pulse.
module alu_result_select_seq #(
    parameter int WIDTH   = 8,
    parameter int NCH     = 8,
    parameter int SELW    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_result_select_seq_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [SELW-1:0]   sel_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [WIDTH-1:0]  result_q;
    logic              valid_q;
    logic              busy_q;
    logic              zero_q;
    logic              neg_q;
    logic              carry_q;
    logic              err_q;

    logic [WIDTH-1:0]  pick_data;
    logic              pick_done;
    logic              pick_carry;
    logic              sel_ok;
    logic              cnt_last;

    // sel_q is only ever loaded with an in-range index, so the loop covers it
    always_comb begin
        pick_data  = '0;
        pick_done  = 1'b0;
        pick_carry = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_q == SELW'(k)) begin
                pick_data  = bus.ch_data[k*WIDTH +: WIDTH];
                pick_done  = bus.ch_done[k];
                pick_carry = bus.ch_carry[k];
            end
        end
    end

    assign sel_ok   = int'(bus.sel) < NCH;
    assign cnt_d    = cnt_q + CW'(1);
    assign cnt_last = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            zero_q   <= 1'b1;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (sel_ok) begin
                            sel_q   <= bus.sel;
                            cnt_q   <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            result_q <= '0;
                            zero_q   <= 1'b1;
                            neg_q    <= 1'b0;
                            carry_q  <= 1'b0;
                            err_q    <= 1'b1;
                            valid_q  <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_WAIT: begin
                    // done wins over timeout in the same cycle
                    if (pick_done) begin
                        result_q <= pick_data;
                        zero_q   <= (pick_data == '0);
                        neg_q    <= pick_data[WIDTH-1];
                        carry_q  <= pick_carry;
                        err_q    <= 1'b0;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (cnt_last) begin
                        result_q <= '0;
                        zero_q   <= 1'b1;
                        neg_q    <= 1'b0;
                        carry_q  <= 1'b0;
                        err_q    <= 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.result     = result_q;
    assign bus.valid      = valid_q;
    assign bus.busy       = busy_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_neg   = neg_q;
    assign bus.flag_carry = carry_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_alu_result_select_seq.sv
// Bench for alu_result_select_seq: cycle model on the default build plus
// directed checks on a 6-channel and a 16-bit/4-channel build.
module tb_alu_result_select_seq;
    localparam int N  = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_result_select_seq_if #(.WIDTH(8),  .NCH(8), .SELW(3)) bm ();
    alu_result_select_seq_if #(.WIDTH(8),  .NCH(6), .SELW(3)) bi ();
    alu_result_select_seq_if #(.WIDTH(16), .NCH(4), .SELW(2)) bw ();

    alu_result_select_seq #(.WIDTH(8), .NCH(8), .SELW(3), .TIMEOUT(TO))
        u_main (.clk(clk), .rst(rst), .bus(bm));
    alu_result_select_seq #(.WIDTH(8), .NCH(6), .SELW(3), .TIMEOUT(TO))
        u_inv (.clk(clk), .rst(rst), .bus(bi));
    alu_result_select_seq #(.WIDTH(16), .NCH(4), .SELW(2), .TIMEOUT(TO))
        u_wide (.clk(clk), .rst(rst), .bus(bw));

    int tests = 0;
    int fails = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: channels viewed as an array, an outstanding request
    // tracked by its channel and age in cycles.
    logic [7:0] chan [N];
    always_comb
        for (int k = 0; k < N; k++) chan[k] = bm.ch_data[k*8 +: 8];

    logic [7:0] m_result;
    logic m_valid, m_busy, m_zero, m_neg, m_carry, m_err, m_wait;
    int   m_sel, m_age;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_result <= 8'h00; m_valid <= 1'b0; m_busy <= 1'b0;
            m_zero <= 1'b1; m_neg <= 1'b0; m_carry <= 1'b0;
            m_err <= 1'b0; m_wait <= 1'b0; m_sel <= 0; m_age <= 0;
        end else begin
            m_valid <= 1'b0;
            if (m_valid) begin
                m_busy <= 1'b0;
            end else if (m_wait) begin
                if (bm.ch_done[m_sel]) begin
                    m_result <= chan[m_sel];
                    m_zero   <= (chan[m_sel] == 8'h00);
                    m_neg    <= chan[m_sel][7];
                    m_carry  <= bm.ch_carry[m_sel];
                    m_err    <= 1'b0;
                    m_valid  <= 1'b1;
                    m_wait   <= 1'b0;
                end else if (m_age == TO - 1) begin
                    m_result <= 8'h00; m_zero <= 1'b1; m_neg <= 1'b0;
                    m_carry  <= 1'b0;  m_err  <= 1'b1;
                    m_valid  <= 1'b1;  m_wait <= 1'b0;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (bm.start) begin
                m_sel  <= int'(bm.sel);
                m_age  <= 0;
                m_wait <= 1'b1;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.valid", 32'(bm.valid), 32'(m_valid));
            chk("m.busy", 32'(bm.busy), 32'(m_busy));
            chk("m.result", 32'(bm.result), 32'(m_result));
            chk("m.zero", 32'(bm.flag_zero), 32'(m_zero));
            chk("m.neg", 32'(bm.flag_neg), 32'(m_neg));
            chk("m.carry", 32'(bm.flag_carry), 32'(m_carry));
            chk("m.err", 32'(bm.err), 32'(m_err));
        end
    end

    task automatic set_ch(input int k, input logic [7:0] v);
        bm.ch_data[k*8 +: 8] = v;
    endtask

    // Pulse start and return the number of clock edges until valid
    task automatic op_main(input logic [2:0] s, input int max,
                           output int lat);
        bm.sel   = s;
        bm.start = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            bm.start = 1'b0;
        end while (!bm.valid && lat < max);
        chk("op_bound", 32'(bm.valid), 32'd1);
    endtask

    int lat, nbusy, nvalid, vpos;

    initial begin
        rst = 1'b1;
        bm.start = 0; bm.sel = 0; bm.ch_data = '0; bm.ch_done = '0; bm.ch_carry = '0;
        bi.start = 0; bi.sel = 0; bi.ch_data = '0; bi.ch_done = '0; bi.ch_carry = '0;
        bw.start = 0; bw.sel = 0; bw.ch_data = '0; bw.ch_done = '0; bw.ch_carry = '0;
        repeat (2) @(negedge clk);
        chk("rst.result", 32'(bm.result), 32'h0);
        chk("rst.zero", 32'(bm.flag_zero), 32'd1);
        chk("rst.busy", 32'(bm.busy), 32'd0);
        chk("rst.valid", 32'(bm.valid), 32'd0);
        chk("rst.err", 32'(bm.err), 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // combinational channel
        set_ch(0, 8'h3C); bm.ch_done = 8'hFF; bm.ch_carry = 8'h00;
        op_main(3'd0, 40, lat);
        chk("comb.lat", 32'(lat), 32'd2);
        chk("comb.result", 32'(bm.result), 32'h3C);
        chk("comb.zero", 32'(bm.flag_zero), 32'd0);
        chk("comb.err", 32'(bm.err), 32'd0);
        @(negedge clk);

        // multi-cycle unit, ignored start in WAIT and in DONE
        set_ch(3, 8'h80); bm.ch_done = 8'hF7; bm.ch_carry = 8'h08;
        set_ch(5, 8'h55);
        bm.sel = 3'd3; bm.start = 1'b1;
        nbusy = 0; nvalid = 0; vpos = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (bm.busy) nbusy++;
            if (bm.valid) begin nvalid++; vpos = i; end
            bm.start = 1'b0;
            if (i == 2) begin bm.start = 1'b1; bm.sel = 3'd5; end
            if (i == 6) bm.ch_done[3] = 1'b1;
            if (i == 7) bm.start = 1'b1;
        end
        chk("multi.busy_cycles", 32'(nbusy), 32'd7);
        chk("multi.valid_count", 32'(nvalid), 32'd1);
        chk("multi.valid_pos", 32'(vpos), 32'd7);
        chk("multi.result", 32'(bm.result), 32'h80);
        chk("multi.neg", 32'(bm.flag_neg), 32'd1);
        chk("multi.carry", 32'(bm.flag_carry), 32'd1);

        // timeout, then a good op clears err
        set_ch(2, 8'h77); bm.ch_done = 8'hFB; bm.ch_carry = 8'hFF;
        op_main(3'd2, 40, lat);
        chk("tmo.lat", 32'(lat), 32'(TO + 1));
        chk("tmo.result", 32'(bm.result), 32'h0);
        chk("tmo.zero", 32'(bm.flag_zero), 32'd1);
        chk("tmo.carry", 32'(bm.flag_carry), 32'd0);
        chk("tmo.err", 32'(bm.err), 32'd1);
        @(negedge clk);
        set_ch(6, 8'hC1); bm.ch_done = 8'hFF; bm.ch_carry = 8'h40;
        op_main(3'd6, 40, lat);
        chk("clr.lat", 32'(lat), 32'd2);
        chk("clr.result", 32'(bm.result), 32'hC1);
        chk("clr.err", 32'(bm.err), 32'd0);
        chk("clr.carry", 32'(bm.flag_carry), 32'd1);
        @(negedge clk);

        // reset in the middle of WAIT
        set_ch(4, 8'h4E); bm.ch_done = 8'hEF;
        bm.sel = 3'd4; bm.start = 1'b1;
        @(negedge clk); bm.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.busy", 32'(bm.busy), 32'd0);
        chk("arst.result", 32'(bm.result), 32'h0);
        chk("arst.zero", 32'(bm.flag_zero), 32'd1);
        chk("arst.neg", 32'(bm.flag_neg), 32'd0);
        chk("arst.carry", 32'(bm.flag_carry), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        repeat (4) begin
            @(negedge clk);
            if (bm.valid) nvalid++;
        end
        chk("arst.no_valid", 32'(nvalid), 32'd0);
        bm.ch_done = 8'hFF;
        op_main(3'd4, 40, lat);
        chk("arst.next_lat", 32'(lat), 32'd2);
        chk("arst.next_result", 32'(bm.result), 32'h4E);
        @(negedge clk);

        // invalid select on a 6-channel build
        bi.ch_data[5*8 +: 8] = 8'h5A; bi.ch_done = 6'h3F;
        bi.sel = 3'd7; bi.start = 1'b1;
        @(negedge clk); bi.start = 1'b0;
        chk("inv.valid_lat1", 32'(bi.valid), 32'd1);
        chk("inv.err", 32'(bi.err), 32'd1);
        chk("inv.result", 32'(bi.result), 32'h0);
        @(negedge clk);
        chk("inv.pulse_end", 32'(bi.valid), 32'd0);
        @(negedge clk);
        bi.sel = 3'd5; bi.start = 1'b1;
        @(negedge clk); bi.start = 1'b0;
        chk("inv.good_lat1", 32'(bi.valid), 32'd0);
        @(negedge clk);
        chk("inv.good_lat2", 32'(bi.valid), 32'd1);
        chk("inv.good_result", 32'(bi.result), 32'h5A);
        chk("inv.good_err", 32'(bi.err), 32'd0);
        @(negedge clk);

        // 16-bit, 4-channel build: zero result and back-to-back period
        bw.ch_data = {16'hFFFF, 16'h8001, 16'h0000, 16'h1234};
        bw.ch_done = 4'hF;
        bw.sel = 2'd0; bw.start = 1'b1;
        @(negedge clk); bw.start = 1'b0;
        @(negedge clk);
        chk("wide.ch0", 32'(bw.result), 32'h1234);
        @(negedge clk);
        bw.sel = 2'd1; bw.start = 1'b1;
        @(negedge clk); bw.start = 1'b0;
        @(negedge clk);
        chk("wide.zero_valid", 32'(bw.valid), 32'd1);
        chk("wide.zero_result", 32'(bw.result), 32'h0);
        chk("wide.zero_flag", 32'(bw.flag_zero), 32'd1);
        @(negedge clk);
        bw.sel = 2'd2; bw.start = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk($sformatf("b2b.valid%0d", i), 32'(bw.valid),
                32'((i % 3) == 2));
        end
        bw.start = 1'b0;
        chk("b2b.result", 32'(bw.result), 32'h8001);
        chk("b2b.neg", 32'(bw.flag_neg), 32'd1);
        repeat (4) @(negedge clk);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_result_select_seq.md
Name: alu_result_select_seq

Overview:
- Parametrised, registered successor of the ALU's 8-to-1 per-bit result multiplexer.
- Selects one of NCH operation-unit results of WIDTH bits and waits for that unit's done strobe, which supports multi-cycle units such as the multiplier and divider.
- Registers the result with zero/negative/carry flags and a one-cycle valid pulse.
- A timeout guards against a unit that never completes.
- Sits between the operation units and the RPN stack write-back/display path.

Parameters:
- WIDTH, 8, data width of every channel and of the result.
- NCH, 8, number of operation channels (must be ≥2).
- SELW, 3, selector width; NCH ≤ 2**SELW.
- TIMEOUT, 16, maximum cycles spent in WAIT before the error return (must be ≥2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a capture; sampled only in IDLE.
- sel  in  SELW  channel index: 0=soma, 1=sub, 2=multi, 3=div, 4=and, 5=or, 6=xor, 7=not.
- ch_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- ch_done  in  NCH  per-channel result-ready; combinational units tie this high.
- ch_carry  in  NCH  per-channel carry/borrow out.
- result  out  WIDTH  registered selected result.
- valid  out  1  one-cycle pulse when result and flags update.
- busy  out  1  high while not in IDLE.
- flag_zero  out  1  result == 0.
- flag_neg  out  1  result[WIDTH-1].
- flag_carry  out  1  registered ch_carry[sel_q].
- err  out  1  last completion was a timeout or an invalid sel.

Behaviour:

Reset (asynchronous, any state):
- State goes to IDLE.
- result=0, valid=0, busy=0, flag_zero=1, flag_neg=0, flag_carry=0, err=0.
- Internal sel_q=0, cnt=0.

States:
- IDLE: busy=0.
  - If start=1 and sel<NCH: sel_q←sel, cnt←0, go to WAIT.
  - If start=1 and sel≥NCH: go to DONE with result←0, flag_zero←1, flag_neg←0, flag_carry←0, err←1.
- WAIT: busy=1.
  - If ch_done[sel_q]=1: result←ch_data[sel_q], flag_zero←(value==0), flag_neg←value MSB, flag_carry←ch_carry[sel_q], err←0; go to DONE.
  - Else if cnt==TIMEOUT-1: result←0, flag_zero←1, flag_neg←0, flag_carry←0, err←1; go to DONE.
  - Else cnt←cnt+1.
  - The done check has priority over the timeout in the same cycle.
- DONE: busy=1 and valid=1 for exactly this one cycle; go to IDLE unconditionally.

Latency:
- start at cycle 0 with done already high gives valid at cycle 2.
- An invalid sel gives valid at cycle 1.
- A timeout gives valid at cycle TIMEOUT+1.

Output holding and ignored inputs:
- result, the flags and err hold their values between completions.
- start is ignored outside IDLE; requests are not queued.
- sel and ch_data changes during WAIT do not affect sel_q.
- ch_data is sampled in the done cycle, not at start.
- A start during DONE is ignored. A start at the first IDLE cycle after DONE is accepted, so the back-to-back period is 3 cycles.

Reset mid-operation:
- Aborts the operation immediately.
- No valid pulse is produced and outputs take their reset values.

Width and implementation:
- No arithmetic is performed on data.
- cnt is sized clog2(TIMEOUT) bits.
- The selection is an indexed part-select or for-loop mux, not per-bit instances.

Test Plan:
- Combinational channel: sel=0, ch_data ch0=8'h3C, ch_done=8'hFF, start pulse at cycle 0 → valid at cycle 2, result=8'h3C, flag_zero=0, flag_neg=0, err=0.
- Multi-cycle unit: sel=3, ch_done[3] held low for 5 cycles then raised with ch3=8'h80, ch_carry[3]=1 → busy for 7 cycles, valid once, result=8'h80, flag_neg=1, flag_carry=1.
- Timeout: sel=2, ch_done[2]=0 forever, TIMEOUT=16 → valid at cycle 17, result=0, flag_zero=1, err=1; the next good op clears err.
- Invalid select: NCH=6 with SELW=3, sel=7 → valid at cycle 1, err=1, result=0.
- Ignored start and reset: start re-asserted with sel=5 during WAIT → first op completes unaffected and no second valid follows. rst asserted mid-WAIT → outputs go to reset values asynchronously, no valid, and the next start works.
- Parametrisation: WIDTH=16, NCH=4, SELW=2, ch1=16'h0000, ch_done=4'hF → result=0, flag_zero=1. Back-to-back starts complete every 3 cycles.
